// File: rtl/fixed_arith_pkg.sv
// Shared fixed-point arithmetic definitions: Q10.10 widths, constants and the
// iterative-unit state encoding used by the power and root blocks.
package fixed_arith_pkg;

  localparam int DATA_W = 20;
  localparam int PROD_W = 40;

  localparam logic [DATA_W-1:0] ONE_Q = 20'h00400;
  localparam logic [DATA_W-1:0] SAT_Q = 20'hFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

endpackage

// File: rtl/fixed_mul_q10.sv
// Combinational unsigned fixed-point multiply: full product, >>FRAC_W
// truncation toward zero, and overflow flag when the result exceeds DW bits.
module fixed_mul_q10 #(
  parameter int DW     = 20,
  parameter int FRAC_W = 10
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] res_o,
  output logic          ovf_o
);

  logic [2*DW-1:0] prod;

  assign prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
  assign res_o = prod[FRAC_W +: DW];
  // Any bit above the retained window means the shifted result does not fit.
  assign ovf_o = |prod[2*DW-1:DW+FRAC_W];

endmodule

// File: rtl/fixed_power.sv
// Iterative Q10.10 power unit, y = x^n, one multiply per cycle with saturation.
// Optional FIXED_POWER_EARLY_EXIT_EN: finish as soon as the result saturates.
module fixed_power
  import fixed_arith_pkg::*;
#(
  parameter int FRAC_W = 10,
  parameter int INT_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [INT_W+FRAC_W-1:0] in_data_1,
  input  logic [2:0]              in_data_2,
  output logic                    out_valid,
  output logic [INT_W+FRAC_W-1:0] out_data
);

  localparam int DW = INT_W + FRAC_W;
  localparam logic [DW-1:0] ONE_L = DW'(1) << FRAC_W;
  localparam logic [DW-1:0] SAT_L = '1;

  arith_state_e  state_q;
  logic [DW-1:0] base_q, acc_q, out_data_q;
  logic [2:0]    cnt_q;
  logic          sat_q, out_valid_q;

  logic [DW-1:0] mul_res, acc_d;
  logic          mul_ovf, sat_d, last_d;

  fixed_mul_q10 #(.DW(DW), .FRAC_W(FRAC_W)) u_mul (
    .a_i   (acc_q),
    .b_i   (base_q),
    .res_o (mul_res),
    .ovf_o (mul_ovf)
  );

  // Saturation is sticky: once hit, later multiplies cannot pull acc back down.
  always_comb begin
    sat_d = sat_q | mul_ovf;
    acc_d = sat_d ? SAT_L : mul_res;
`ifdef FIXED_POWER_EARLY_EXIT_EN
    last_d = (cnt_q == 3'd1) || mul_ovf;
`else
    last_d = (cnt_q == 3'd1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          if (in_valid) begin
            base_q  <= in_data_1;
            cnt_q   <= in_data_2;
            acc_q   <= ONE_L;
            sat_q   <= 1'b0;
            state_q <= (in_data_2 == 3'd0) ? DONE : MUL;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          sat_q <= sat_d;
          cnt_q <= cnt_q - 3'd1;
          if (last_d) state_q <= DONE;
        end
        DONE: begin
          out_valid_q <= 1'b1;
          out_data_q  <= acc_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_power.sv
// Directed self-checking bench for fixed_power: latency, values, saturation,
// ignored mid-job input, and reset behaviour.
module tb_fixed_power;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic [19:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FIXED_POWER_EARLY_EXIT_EN
  localparam int SAT7_LAT = 3;
`else
  localparam int SAT7_LAT = 8;
`endif

  fixed_power dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one job at E0, then watch negedges after E1..E20 for the strobe.
  task automatic run_job(input string tag, input logic [19:0] base, input logic [2:0] n,
                         input logic [19:0] exp_d, input int exp_lat);
    int          lat = 0;
    logic [19:0] got = '0;
    int          dirty = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data_1 = base; in_data_2 = n;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k; got = out_data;
        break;
      end else if (out_data != 20'h0) dirty++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, {12'h0, got}, {12'h0, exp_d});
    chk({tag, "_zero_before"}, 32'(dirty), 32'd0);
    @(negedge clk);
    chk({tag, "_vld_after"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_zero_after"}, {12'h0, out_data}, 32'd0);
  endtask

  initial begin
    int pulses;
    int lat;
    logic [19:0] got;
    int dirty;

    rst = 1'b1; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", {31'h0, out_valid}, 32'd0);
    chk("rst_data", {12'h0, out_data}, 32'd0);
    rst = 1'b0;

    run_job("pow_2_3",    20'h00800, 3'd3, 20'h02000, 4);
    run_job("pow_n0",     20'h12345, 3'd0, 20'h00400, 1);
    run_job("pow_1p5_2",  20'h00600, 3'd2, 20'h00900, 3);
    run_job("pow_trunc",  20'h00001, 3'd2, 20'h00000, 3);
    run_job("pow_zero_3", 20'h00000, 3'd3, 20'h00000, 4);
    run_job("pow_zero_0", 20'h00000, 3'd0, 20'h00400, 1);
    run_job("pow_max_1",  20'hFFFFF, 3'd1, 20'hFFFFF, 2);
    run_job("pow_31_2",   20'h07C00, 3'd2, 20'hF0400, 3);
    run_job("pow_32_2",   20'h08000, 3'd2, 20'hFFFFF, 3);
    run_job("pow_250_7",  20'h3E800, 3'd7, 20'hFFFFF, SAT7_LAT);

    // Second in_valid at E2 of an n=5 job must be dropped.
    @(negedge clk);
    in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data_1 = 20'h00C00; in_data_2 = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0; lat = 0; got = '0;
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin lat = k; got = out_data; end
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_lat", 32'(lat), 32'd6);
    chk("ign_data", {12'h0, got}, 32'h08000);

    // Reset at E3 of an n=6 job discards it.
    @(negedge clk);
    in_valid = 1'b1; in_data_1 = 20'h00600; in_data_2 = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0; dirty = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (out_data != 20'h0) dirty++;
    end
    chk("rst_mid_pulses", 32'(pulses), 32'd0);
    chk("rst_mid_data", 32'(dirty), 32'd0);
    run_job("post_rst", 20'h00800, 3'd1, 20'h00800, 2);

    // rst and in_valid on the same edge: input dropped.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rst_collide", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
